// File: rtl/grid_arbiter_if.sv
// Requester-side bundle of the level-grid read arbiter.
// Three coordinate/request lanes in, acknowledge and cell codes back.
interface grid_arbiter_if;
    logic [2:0] req;
    logic [5:0] grid_x0;
    logic [5:0] grid_x1;
    logic [5:0] grid_x2;
    logic [4:0] grid_y0;
    logic [4:0] grid_y1;
    logic [4:0] grid_y2;
    logic [2:0] ack;
    logic [2:0] grid_out0;
    logic [2:0] grid_out1;
    logic [2:0] grid_out2;

    modport master (
        output req,
        output grid_x0, grid_x1, grid_x2,
        output grid_y0, grid_y1, grid_y2,
        input  ack,
        input  grid_out0, grid_out1, grid_out2
    );

    modport slave (
        input  req,
        input  grid_x0, grid_x1, grid_x2,
        input  grid_y0, grid_y1, grid_y2,
        output ack,
        output grid_out0, grid_out1, grid_out2
    );
endinterface

// File: rtl/grid_arbiter.sv
// Round-robin sharing of the grid RAM read port among three requesters.
// Reads are pipelined; a tag shift register steers returning data.
module grid_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic         clock,
    input  logic         reset,
    grid_arbiter_if.slave rq,
    output logic [10:0]  mem_addr,
    output logic         mem_en,
    input  logic [2:0]   mem_data
);
    typedef struct packed {
        logic       v;
        logic [1:0] id;
    } tag_t;

    tag_t        tags [MEM_LATENCY+1];
    tag_t        ret;
    logic [2:0]  busy;
    logic [2:0]  elig;
    logic [2:0]  gnt;
    logic [1:0]  last;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        hit;
    logic [10:0] addr_sel;
    logic [2:0]  ack_q;
    logic [2:0]  out0_q;
    logic [2:0]  out1_q;
    logic [2:0]  out2_q;

    assign elig = rq.req & ~busy;
    assign ret  = tags[MEM_LATENCY];

    // Search from the requester after the last winner, wrapping once.
    always_comb begin
        hit = 1'b0;
        win = last;
        idx = last;
        for (int i = 0; i < 3; i++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!hit && elig[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

    assign gnt = hit ? 3'(3'b001 << win) : 3'b000;

    always_comb begin
        addr_sel = mem_addr;
        unique case (1'b1)
            gnt[0]: addr_sel = {rq.grid_y0, rq.grid_x0};
            gnt[1]: addr_sel = {rq.grid_y1, rq.grid_x1};
            gnt[2]: addr_sel = {rq.grid_y2, rq.grid_x2};
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
            busy     <= '0;
            last     <= 2'd2;
            ack_q    <= '0;
            out0_q   <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            for (int i = 0; i <= MEM_LATENCY; i++)
                tags[i] <= '0;
        end else begin
            mem_en <= hit;
            if (hit) begin
                mem_addr <= addr_sel;
                last     <= win;
            end
            tags[0] <= '{v: hit, id: win};
            for (int i = 1; i <= MEM_LATENCY; i++)
                tags[i] <= tags[i-1];
            ack_q <= ret.v ? 3'(3'b001 << ret.id) : 3'b000;
            if (ret.v) begin
                unique case (ret.id)
                    2'd0: out0_q <= mem_data;
                    2'd1: out1_q <= mem_data;
                    2'd2: out2_q <= mem_data;
                    default: ;
                endcase
            end
            // Busy drops after the ack cycle so a held req is not re-granted.
            busy <= (busy | gnt) & ~ack_q;
        end
    end

    assign rq.ack       = ack_q;
    assign rq.grid_out0 = out0_q;
    assign rq.grid_out1 = out1_q;
    assign rq.grid_out2 = out2_q;
endmodule

// File: tb/tb_grid_arbiter.sv
// Randomized bench for grid_arbiter at MEM_LATENCY 1, 2 and 3 in parallel.
// A transaction-level model predicts grants, acks and returned cell codes.
module tb_grid_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  mem [2048];
    logic [2:0]  req_d [3];
    logic [5:0]  xs [3][3];
    logic [4:0]  ys [3][3];
    logic [2:0]  ack_w [3];
    logic        en_w [3];
    logic [10:0] addr_w [3];
    logic [2:0]  go_w [3][3];

    int checks = 0;
    int failures = 0;
    int n = 0;

    bit          out_m [3][3];
    int          ack_t [3][3];
    logic [2:0]  dat_m [3][3];
    logic [2:0]  gexp [3][3];
    bit          wait_m [3][3];
    int          last_m [3];
    bit          en_e [3];
    logic [10:0] addr_e [3];

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L = g + 1;
        grid_arbiter_if bus ();
        logic [10:0] maddr;
        logic        men;
        logic [2:0]  mdata;
        logic [2:0]  pipe [L];

        assign bus.req     = req_d[g];
        assign bus.grid_x0 = xs[g][0];
        assign bus.grid_x1 = xs[g][1];
        assign bus.grid_x2 = xs[g][2];
        assign bus.grid_y0 = ys[g][0];
        assign bus.grid_y1 = ys[g][1];
        assign bus.grid_y2 = ys[g][2];
        assign ack_w[g]    = bus.ack;
        assign en_w[g]     = men;
        assign addr_w[g]   = maddr;
        assign go_w[g][0]  = bus.grid_out0;
        assign go_w[g][1]  = bus.grid_out1;
        assign go_w[g][2]  = bus.grid_out2;

        always @(posedge clock) begin
            pipe[0] <= men ? mem[maddr] : 3'($urandom);
            for (int i = 1; i < L; i++)
                pipe[i] <= pipe[i-1];
        end
        assign mdata = pipe[L-1];

        grid_arbiter #(.MEM_LATENCY(L)) dut (
            .clock    (clock),
            .reset    (reset),
            .rq       (bus),
            .mem_addr (maddr),
            .mem_en   (men),
            .mem_data (mdata)
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            logic [2:0] ae;
            ae = '0;
            for (int k = 0; k < 3; k++)
                if (out_m[d][k] && ack_t[d][k] == n) begin
                    ae[k] = 1'b1;
                    gexp[d][k] = dat_m[d][k];
                end
            chk($sformatf("ack d%0d n%0d", d, n), ack_w[d], ae);
            chk($sformatf("en d%0d n%0d", d, n), en_w[d], en_e[d]);
            chk($sformatf("addr d%0d n%0d", d, n), addr_w[d], addr_e[d]);
            for (int k = 0; k < 3; k++)
                chk($sformatf("out%0d d%0d n%0d", k, d, n),
                    go_w[d][k], gexp[d][k]);
        end
    endtask

    task automatic arb();
        for (int d = 0; d < 3; d++) begin
            int w;
            int idx;
            logic [10:0] a;
            w = -1;
            idx = last_m[d];
            for (int i = 0; i < 3; i++) begin
                idx = (idx + 1) % 3;
                if (w < 0 && req_d[d][idx] &&
                    !(out_m[d][idx] && n <= ack_t[d][idx]))
                    w = idx;
            end
            if (w >= 0) begin
                a = {ys[d][w], xs[d][w]};
                out_m[d][w] = 1'b1;
                ack_t[d][w] = n + d + 3;
                dat_m[d][w] = mem[a];
                en_e[d] = 1'b1;
                addr_e[d] = a;
                last_m[d] = w;
            end else begin
                en_e[d] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        arb();
        @(posedge clock);
        #1;
        n++;
        check_all();
    endtask

    task automatic drive(input int pct, input logic [2:0] mask);
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 3; k++) begin
                if (wait_m[d][k] && out_m[d][k] && ack_t[d][k] == n)
                    wait_m[d][k] = 1'b0;
                if (!wait_m[d][k]) begin
                    if (mask[k] && $urandom_range(99) < pct) begin
                        wait_m[d][k] = 1'b1;
                        req_d[d][k] = 1'b1;
                        xs[d][k] = 6'($urandom);
                        ys[d][k] = 5'($urandom);
                    end else begin
                        req_d[d][k] = 1'b0;
                    end
                end
            end
    endtask

    task automatic raise(input int k, input int x, input int y);
        for (int d = 0; d < 3; d++) begin
            req_d[d][k] = 1'b1;
            xs[d][k] = 6'(x);
            ys[d][k] = 5'(y);
            wait_m[d][k] = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s ack d%0d", tag, d), ack_w[d], 0);
            chk($sformatf("%s en d%0d", tag, d), en_w[d], 0);
            chk($sformatf("%s addr d%0d", tag, d), addr_w[d], 0);
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s out%0d d%0d", tag, k, d), go_w[d][k], 0);
        end
    endtask

    task automatic rst();
        reset = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 3; k++) begin
                req_d[d][k] = 1'b0;
                wait_m[d][k] = 1'b0;
            end
        #1;
        check_zero("rst_async");
        @(posedge clock);
        #1;
        check_zero("rst_held");
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 3; k++) begin
                out_m[d][k] = 1'b0;
                ack_t[d][k] = 0;
                gexp[d][k] = '0;
            end
            last_m[d] = 2;
            en_e[d] = 1'b0;
            addr_e[d] = '0;
        end
        n = 0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_d[d] = '0;
            for (int k = 0; k < 3; k++) begin
                xs[d][k] = '0;
                ys[d][k] = '0;
            end
        end
        for (int i = 0; i < 2048; i++)
            mem[i] = 3'($urandom);
        mem[197] = 3'd4;
        #12;
        rst();

        raise(0, 5, 3);
        tick();
        chk("tp1_addr", addr_w[0], 197);
        chk("tp1_en", en_w[0], 1);
        drive(0, 3'b000);
        tick();
        drive(0, 3'b000);
        tick();
        chk("tp1_ack", ack_w[0], 1);
        chk("tp1_data", go_w[0][0], 4);
        repeat (6) begin drive(0, 3'b000); tick(); end

        rst();
        for (int k = 0; k < 3; k++)
            raise(k, $urandom_range(63), $urandom_range(31));
        repeat (12) begin
            tick();
            if (n >= 3 && n <= 5)
                chk($sformatf("tp2_order n%0d", n), ack_w[0], 1 << (n - 3));
            drive(0, 3'b000);
        end

        rst();
        repeat (40) begin drive(100, 3'b010); tick(); end
        repeat (300) begin drive(60, 3'b101); tick(); end
        repeat (1500) begin drive(50, 3'b111); tick(); end

        rst();
        raise(0, 9, 4);
        raise(1, 17, 22);
        tick();
        drive(0, 3'b000);
        tick();
        rst();
        repeat (8) begin drive(0, 3'b000); tick(); end
        raise(0, 10, 7);
        raise(1, 1, 1);
        raise(2, 2, 2);
        tick();
        chk("rst_first_addr", addr_w[0], 458);
        repeat (10) begin drive(0, 3'b000); tick(); end

        raise(0, 63, 31);
        tick();
        chk("corner_max", addr_w[1], 2047);
        repeat (8) begin drive(0, 3'b000); tick(); end
        raise(1, 0, 0);
        tick();
        chk("corner_min", addr_w[2], 0);
        chk("corner_min_en", en_w[2], 1);
        repeat (8) begin drive(0, 3'b000); tick(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
